// File: rtl/lc3b_types.sv
// Shared LC-3b types: default sizing for the per-PC branch history table.
package lc3b_types;

  localparam int BHT_ENTRIES = 512;
  localparam int BHT_HIST_W  = 16;
  localparam int BHT_IDX_W   = $clog2(BHT_ENTRIES);

  typedef logic [BHT_IDX_W-1:0]  lc3b_bht_index;
  typedef logic [BHT_HIST_W-1:0] lc3b_bht_hist;

endpackage

// File: rtl/bht_clear_ctrl.sv
// Clear-sweep controller for the branch history table: walks every entry
// writing zero after reset or flush, then reports ready.
module bht_clear_ctrl
  import lc3b_types::*;
#(
  parameter  int ENTRIES = BHT_ENTRIES,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  output logic             ready,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_addr
);

  typedef enum logic {
    CLEAR,
    READY
  } clr_state_e;

  clr_state_e       state, state_nxt;
  logic [IDX_W-1:0] clr_ptr, clr_ptr_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  // A flush during the sweep only rewinds the pointer; the write of that cycle is skipped.
  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    clr_we      = 1'b0;
    unique case (state)
      CLEAR: begin
        if (flush) begin
          clr_ptr_nxt = '0;
        end else begin
          clr_we      = 1'b1;
          clr_ptr_nxt = clr_ptr + IDX_W'(1);
          if (clr_ptr == IDX_W'(ENTRIES - 1)) begin
            state_nxt = READY;
          end
        end
      end
      READY: begin
        if (flush) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  assign ready    = (state == READY);
  assign clr_addr = clr_ptr;

endmodule

// File: rtl/branch_history_table.sv
// Per-PC local branch history table: registered read port, independent update port.
// Optional macro BHT_BYPASS_EN forwards a same-cycle same-index update to the read.
module branch_history_table
  import lc3b_types::*;
#(
  parameter  int ENTRIES = BHT_ENTRIES,
  parameter  int HIST_W  = BHT_HIST_W,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  output logic              ready,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              rd_valid,
  output logic [HIST_W-1:0] rd_hist,
  input  logic              upd_en,
  input  logic [IDX_W-1:0]  upd_index,
  input  logic              upd_taken
);

  function automatic logic [HIST_W-1:0] shift_in(input logic [HIST_W-1:0] old,
                                                 input logic              taken);
    return {old[HIST_W-2:0], taken};
  endfunction

  logic              clr_we;
  logic [IDX_W-1:0]  clr_addr;
  logic [HIST_W-1:0] mem [ENTRIES];

  logic              accept, rd_fire, upd_fire;
  logic [HIST_W-1:0] rd_old, upd_new, rd_data;
  logic              vld_p1;
  logic [HIST_W-1:0] rd_hist_p1;

  bht_clear_ctrl #(
    .ENTRIES (ENTRIES)
  ) u_clear_ctrl (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Stage p0: request qualification, table lookup and the shifted update value.
  assign accept   = ready & ~flush & reset_n;
  assign rd_fire  = rd_en & accept;
  assign upd_fire = upd_en & accept;
  assign rd_old   = mem[rd_index];
  assign upd_new  = shift_in(mem[upd_index], upd_taken);

`ifdef BHT_BYPASS_EN
  assign rd_data = (upd_fire && (upd_index == rd_index)) ? upd_new : rd_old;
`else
  assign rd_data = rd_old;
`endif

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (upd_fire) begin
      mem[upd_index] <= upd_new;
    end
  end

  // Stage p1: registered read result; forced to zero whenever the table is unavailable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1     <= 1'b0;
      rd_hist_p1 <= '0;
    end else if (!ready || flush) begin
      vld_p1     <= 1'b0;
      rd_hist_p1 <= '0;
    end else if (rd_fire) begin
      vld_p1     <= 1'b1;
      rd_hist_p1 <= rd_data;
    end else begin
      vld_p1     <= 1'b0;
    end
  end

  assign rd_valid = vld_p1;
  assign rd_hist  = rd_hist_p1;

endmodule

// File: doc/branch_history_table.md
Name: branch_history_table

Overview:
Parametrised per-PC local branch history table. It holds ENTRIES shift registers of HIST_W bits, each recording the most recent branch outcomes for one PC index. It has a registered read port for the fetch/predict stage and an independent update port for the resolve stage. Reset and flush clear the table with a sequential sweep; `ready` gates all traffic while a sweep runs.

Parameters:
ENTRIES, 512, number of history entries; power of two, >= 2
HIST_W, 16, bits of history per entry; >= 2
IDX_W, $clog2(ENTRIES), index width; derived, never overridden

Ports:
clk  input  1  system clock, all state on posedge
reset_n  input  1  synchronous active-low reset
flush  input  1  request full table clear (pipeline recovery)
ready  output  1  high when table accepts reads/updates
rd_en  input  1  read request
rd_index  input  IDX_W  PC-derived read index
rd_valid  output  1  rd_hist holds data for the request of the previous cycle
rd_hist  output  HIST_W  history of sampled entry, bit 0 = newest outcome
upd_en  input  1  update request
upd_index  input  IDX_W  PC-derived update index
upd_taken  input  1  resolved branch outcome (1 = taken)

Behaviour:
- One clock (clk); reset_n is synchronous and active-low.
- State machine: CLEAR, READY.
- Reset: posedge with reset_n=0 → state=CLEAR, clr_ptr=0, ready=0, rd_valid=0, rd_hist=0. Table contents are undefined until the sweep completes.
- CLEAR: each posedge with reset_n=1 writes 0 to entry clr_ptr and increments clr_ptr.
  - The edge that writes entry ENTRIES-1 moves state to READY; ready=1 from the next cycle.
  - Total: exactly ENTRIES cycles after reset_n rises. clr_ptr wraps to 0 in that same edge.
- ready = (state==READY); registered, no combinational path from inputs.
- In CLEAR, rd_en and upd_en are ignored; rd_valid=0 and rd_hist holds 0.
- flush=1 in READY → next state CLEAR, clr_ptr=0, rd_valid=0, rd_hist=0. Any rd_en/upd_en in the same cycle are dropped.
- flush=1 during CLEAR restarts the sweep at clr_ptr=0.
- reset_n=0 at any time overrides flush and every request.
- Read, latency 1: rd_en & ready at edge N samples data[rd_index]. At N+1, rd_valid=1 and rd_hist=value.
  - Without rd_en, rd_valid=0 and rd_hist holds its last value.
- Update: upd_en & ready at edge N writes data[upd_index] <= {data[upd_index][HIST_W-2:0], upd_taken}. The MSB is discarded; no saturation.
  - A read issued at N+1 or later sees the new value.
- Same-cycle read and update, different index: both proceed independently.
- Same-cycle read and update, same index: result defined by BHT_BYPASS_EN (see below).
- Back-to-back updates to one index shift once per cycle, with no lost updates.

Optional Feature:
Macro BHT_BYPASS_EN.
- Defined: a same-cycle same-index read returns the post-update value {old[HIST_W-2:0], upd_taken}.
- Undefined: it returns the pre-update value.
- Latency and all other behaviour are identical either way.

Decomposition:
- lc3b_types gains BHT_ENTRIES and BHT_HIST_W constants, plus typedefs lc3b_bht_index (IDX_W) and lc3b_bht_hist (HIST_W) for defaults.
- FSM state enum is local to the module.
- One sub-module is natural: bht_clear_ctrl, holding the CLEAR/READY FSM, clr_ptr and the ready output. Its inputs are reset_n and flush; its outputs are clr_we and clr_addr.
- Storage array stays in the top module as an inferred RAM/logic array.

Test Plan:
- Reset, ENTRIES=8: hold reset_n=0 for 2 cycles, then release → ready=0 for exactly 8 cycles, then 1. A read of every index returns 0.
- Shift order: updates to index 5 with taken=1,0,1,1, then read 5 → rd_valid=1 one cycle later, rd_hist=16'h000B.
- Wrap: 17 taken=1 updates to index 3 with HIST_W=16, then read → 16'hFFFF. One more taken=0 update → 16'hFFFE.
- Collision: index 2 holds 16'h0001; same-cycle update taken=1 and read of index 2 → 16'h0003 with BHT_BYPASS_EN, 16'h0001 without. A following read returns 16'h0003 in both builds.
- Flush mid-traffic: flush alongside upd_en to index 1 → update dropped, ready=0 for ENTRIES cycles, rd_valid=0 throughout. Index 1 then reads 0.
- Gating and reset override: rd_en/upd_en asserted during CLEAR → no rd_valid and no table change. reset_n=0 during flush restarts the sweep from 0.
